packet_inject_arbiter: RTL and testbench

PACKET_INJECT_ARBITER -- requirements
Module: packet_inject_arbiter

---
 rtl/packet_inject_arbiter_if.sv | 47 ++++
 rtl/packet_inject_arbiter.sv | 118 +++++++++++
 tb/tb_packet_inject_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_inject_arbiter_if.sv
// Flit type and the bundled source/switch/status signals of the packet injection arbiter.

package packet_inject_arbiter_pkg;

    localparam int unsigned FLIT_W = 16;

    typedef struct packed {
        logic [FLIT_W-1:0] data;
    } flit_t;

endpackage

interface packet_inject_arbiter_if #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
);
    localparam int unsigned GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_REQ-1:0]                  req_valid;
    packet_inject_arbiter_pkg::flit_t    req_flit [NUM_REQ];
    logic [NUM_REQ-1:0]                  req_last;
    logic [NUM_REQ-1:0]                  req_ready;
    packet_inject_arbiter_pkg::flit_t    out_flit;
    logic                                out_valid;
    logic                                sw_ready;
    logic                                packet_sent;
    logic                                grant_valid;
    logic [GID_W-1:0]                    grant_id;
    logic [CNT_W-1:0]                    outstanding;
    logic                                err_underflow;

    // Arbiter side
    modport slave (
        input  req_valid, req_flit, req_last, sw_ready, packet_sent,
        output req_ready, out_flit, out_valid, grant_valid, grant_id,
               outstanding, err_underflow
    );

    // Sources, switch and status observer side
    modport master (
        output req_valid, req_flit, req_last, sw_ready, packet_sent,
        input  req_ready, out_flit, out_valid, grant_valid, grant_id,
               outstanding, err_underflow
    );

endinterface

// File: rtl/packet_inject_arbiter.sv
// Round-robin wormhole arbiter injecting packets from NUM_REQ sources into one
// switch input port, throttled by a count of packets still in flight.

module packet_inject_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    packet_inject_arbiter_if.slave  bus
);

    localparam int unsigned GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [GID_W-1:0] LAST_INIT = GID_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;
    logic [GID_W-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic               err_q, err_d;

    logic               tail_xfer_c;
    logic               found_c;
    logic [GID_W-1:0]   winner_c;
    logic [GID_W-1:0]   idx_c;

    // Round-robin search starting one past the last source that finished a packet
    always_comb begin
        found_c  = 1'b0;
        winner_c = '0;
        idx_c    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx_c = GID_W'((32'(last_grant_q) + k + 32'd1) % NUM_REQ);
            if (!found_c && bus.req_valid[idx_c]) begin
                found_c  = 1'b1;
                winner_c = idx_c;
            end
        end
    end

    // FSM next state and the combinational datapath mux toward the switch
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        tail_xfer_c   = 1'b0;
        bus.out_flit  = '0;
        bus.out_valid = 1'b0;
        bus.req_ready = '0;

        unique case (state_q)
            IDLE: begin
                if (found_c && (outstanding_q < MAX_CNT)) begin
                    grant_id_d = winner_c;
                    state_d    = SEND;
                end
            end
            SEND: begin
                bus.out_flit             = bus.req_flit[grant_id_q];
                bus.out_valid            = bus.req_valid[grant_id_q];
                bus.req_ready[grant_id_q] = bus.sw_ready;
                // Grant is held until the tail flit actually moves
                if (bus.req_valid[grant_id_q] && bus.sw_ready && bus.req_last[grant_id_q]) begin
                    tail_xfer_c  = 1'b1;
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end
            end
        endcase
    end

    // In-flight packet count; a simultaneous tail and packet_sent cancel out
    always_comb begin
        outstanding_d = outstanding_q;
        err_d         = err_q;
        unique case ({tail_xfer_c, bus.packet_sent})
            2'b10: outstanding_d = outstanding_q + CNT_W'(1);
            2'b01: begin
                if (outstanding_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    outstanding_d = outstanding_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // State registers; reset abandons any packet in progress without counting it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_id_q    <= '0;
            last_grant_q  <= LAST_INIT;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign bus.grant_valid   = (state_q == SEND);
    assign bus.grant_id      = grant_id_q;
    assign bus.outstanding   = outstanding_q;
    assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_packet_inject_arbiter.sv
// Directed bench: source queues drive flits, a negedge monitor checks every
// switch-side transfer against a scoreboard of hand-ordered expected flits.

module tb_packet_inject_arbiter;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    packet_inject_arbiter_if #(.NUM_REQ(N), .MAX_OUTSTANDING(2)) bus ();

    packet_inject_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] data;
        logic        last;
    } ent_t;

    ent_t        srcq [N][$];
    logic [17:0] sb [$];
    int          n_cmp = 0;
    int          n_err = 0;

    logic [N-1:0] exp_rdy;
    logic         exp_ov;
    logic [17:0]  exp_e;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Present the head of each source queue
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                bus.req_valid[i]     = 1'b1;
                bus.req_flit[i].data = srcq[i][0].data;
                bus.req_last[i]      = srcq[i][0].last;
            end else begin
                bus.req_valid[i]     = 1'b0;
                bus.req_flit[i].data = '0;
                bus.req_last[i]      = 1'b0;
            end
        end
    endtask

    // Queue an n-flit packet at a source; the first n_exp flits are expected on the switch
    task automatic add_pkt(input int src, input int pkt, input int n, input int n_exp);
        ent_t        e;
        logic [1:0]  s;
        for (int k = 0; k < n; k++) begin
            e.data = {src[3:0], pkt[3:0], k[7:0]};
            e.last = (k == n - 1);
            srcq[src].push_back(e);
            s = src[1:0];
            if (k < n_exp) sb.push_back({s, e.data});
        end
        drive();
    endtask

    // One clock: note accepted flits before the edge, retire them after it
    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        end
        drive();
    endtask

    // Monitor: per-cycle handshake rules plus scoreboard check of each transfer
    always @(negedge clk) begin
        if (mon_en) begin
            exp_rdy = bus.grant_valid ? (N'(bus.sw_ready) << bus.grant_id) : '0;
            chk("req_ready", int'(bus.req_ready), int'(exp_rdy));
            exp_ov = bus.grant_valid && bus.req_valid[bus.grant_id];
            chk("out_valid", int'(bus.out_valid), int'(exp_ov));
            if (bus.out_valid && bus.sw_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_xfer", int'(bus.out_flit.data), -1);
                end else begin
                    exp_e = sb.pop_front();
                    chk("xfer_gid", int'(bus.grant_id), int'(exp_e[17:16]));
                    chk("xfer_data", int'(bus.out_flit.data), int'(exp_e[15:0]));
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.sw_ready    = 1'b1;
        bus.packet_sent = 1'b0;
        drive();
        repeat (2) step();
        rst    = 1'b0;
        mon_en = 1'b1;

        // Reset state
        chk("rst_grant_valid", int'(bus.grant_valid), 0);
        chk("rst_outstanding", int'(bus.outstanding), 0);
        chk("rst_err", int'(bus.err_underflow), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_req_ready", int'(bus.req_ready), 0);

        // All four request one-flit packets: 0,1, stall at 2, 2 after a sent, stall, 3
        for (int s = 0; s < N; s++) add_pkt(s, 0, 1, 1);
        step();
        chk("a_gv0", int'(bus.grant_valid), 1);
        chk("a_gid0", int'(bus.grant_id), 0);
        step(); step();
        chk("a_gid1", int'(bus.grant_id), 1);
        step();
        chk("a_out2", int'(bus.outstanding), 2);
        chk("a_idle", int'(bus.grant_valid), 0);
        repeat (3) step();
        chk("a_stall_gv", int'(bus.grant_valid), 0);
        chk("a_stall_out", int'(bus.outstanding), 2);
        bus.packet_sent = 1'b1; step(); bus.packet_sent = 1'b0;
        chk("a_dec", int'(bus.outstanding), 1);
        chk("a_dec_gv", int'(bus.grant_valid), 0);
        step();
        chk("a_gid2", int'(bus.grant_id), 2);
        chk("a_gv2", int'(bus.grant_valid), 1);
        step();
        chk("a_out2b", int'(bus.outstanding), 2);
        repeat (2) step();
        chk("a_stall2", int'(bus.grant_valid), 0);
        bus.packet_sent = 1'b1; step(); bus.packet_sent = 1'b0;
        step();
        chk("a_gv3", int'(bus.grant_valid), 1);
        chk("a_gid3", int'(bus.grant_id), 3);
        step();
        chk("a_out_end", int'(bus.outstanding), 2);
        bus.packet_sent = 1'b1; step(); step(); bus.packet_sent = 1'b0;
        chk("a_drain", int'(bus.outstanding), 0);
        chk("a_err", int'(bus.err_underflow), 0);

        // Source 2 three-flit packet with sw_ready 1,0,1,1 while source 0 waits
        add_pkt(2, 1, 3, 3);
        step();
        chk("b_gid", int'(bus.grant_id), 2);
        add_pkt(0, 1, 1, 1);
        step();
        bus.sw_ready = 1'b0;
        step();
        chk("b_hold_gv", int'(bus.grant_valid), 1);
        chk("b_hold_gid", int'(bus.grant_id), 2);
        bus.sw_ready = 1'b1;
        step(); step();
        chk("b_gap_gv", int'(bus.grant_valid), 0);
        chk("b_out1", int'(bus.outstanding), 1);
        step();
        chk("b_gv0", int'(bus.grant_valid), 1);
        chk("b_gid0", int'(bus.grant_id), 0);
        step();
        chk("b_out2", int'(bus.outstanding), 2);

        // Tail and packet_sent together with outstanding 1
        bus.packet_sent = 1'b1; step(); bus.packet_sent = 1'b0;
        chk("c_out1", int'(bus.outstanding), 1);
        add_pkt(1, 1, 1, 1);
        step();
        chk("c_gid1", int'(bus.grant_id), 1);
        bus.packet_sent = 1'b1; step(); bus.packet_sent = 1'b0;
        chk("c_same_cycle", int'(bus.outstanding), 1);
        chk("c_gv", int'(bus.grant_valid), 0);

        // Underflow is sticky until reset
        bus.packet_sent = 1'b1; step();
        chk("d_out0", int'(bus.outstanding), 0);
        chk("d_no_err", int'(bus.err_underflow), 0);
        step(); bus.packet_sent = 1'b0;
        chk("d_out_stay0", int'(bus.outstanding), 0);
        chk("d_err", int'(bus.err_underflow), 1);
        repeat (3) step();
        chk("d_err_sticky", int'(bus.err_underflow), 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("d_err_clr", int'(bus.err_underflow), 0);

        // Reset in the second flit of a four-flit packet from source 1
        add_pkt(1, 2, 4, 2);
        step();
        chk("e_gid1", int'(bus.grant_id), 1);
        step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("e_gv", int'(bus.grant_valid), 0);
        chk("e_out", int'(bus.outstanding), 0);
        srcq[1].delete();
        drive();
        add_pkt(0, 2, 1, 1);
        add_pkt(1, 3, 1, 1);
        step();
        chk("e_win0", int'(bus.grant_id), 0);
        step(); step();
        chk("e_then1", int'(bus.grant_id), 1);
        step();
        chk("e_out2", int'(bus.outstanding), 2);

        // Lone requester 3 is granted every second cycle
        bus.packet_sent = 1'b1; step(); step(); bus.packet_sent = 1'b0;
        add_pkt(3, 4, 1, 1);
        add_pkt(3, 5, 1, 1);
        step();
        chk("f_gv_a", int'(bus.grant_valid), 1);
        chk("f_gid_a", int'(bus.grant_id), 3);
        step();
        chk("f_gap", int'(bus.grant_valid), 0);
        step();
        chk("f_gv_b", int'(bus.grant_valid), 1);
        chk("f_gid_b", int'(bus.grant_id), 3);
        step();
        chk("f_out2", int'(bus.outstanding), 2);
        add_pkt(3, 6, 1, 1);
        step();
        chk("f_stall", int'(bus.grant_valid), 0);
        bus.packet_sent = 1'b1; step(); bus.packet_sent = 1'b0;
        step();
        chk("f_gv_c", int'(bus.grant_valid), 1);
        step();
        repeat (2) step();
        chk("sb_drained", sb.size(), 0);
        chk("src3_empty", srcq[3].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
